// File: rtl/iir_pkg.sv
// Shared helpers for the Direct Form I IIR filter: ceiling log2,
// accumulator sizing and signed saturation.
package iir_pkg;

  // Width of the working value used by the saturation helper
  localparam int unsigned SAT_W = 64;

  // Ceiling log2, returns 0 for v <= 1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Accumulator width large enough that 2M+1 full-scale products never overflow
  function automatic int unsigned acc_width(input int unsigned m,
                                            input int unsigned input_width,
                                            input int unsigned precision,
                                            input int unsigned coeff_width);
    int unsigned wmax;
    wmax = (input_width > precision) ? input_width : precision;
    return wmax + coeff_width + clog2(2 * m + 1);
  endfunction

  // Clamp a signed value to the range of a signed 'width'-bit number
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] value,
                                                  input int unsigned width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/iir_delay_line.sv
// Tapped shift register with synchronous active-high clear.
// Ports:
//   i_clk  - clock, rising edge
//   i_clr  - synchronous clear of every tap
//   i_d    - value shifted in each clock
//   o_taps - o_taps[0] is the newest stored value, o_taps[DEPTH-1] the oldest
module iir_delay_line #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_clr,
  input  logic [WIDTH-1:0]             i_d,
  output logic [DEPTH-1:0][WIDTH-1:0]  o_taps
);

  logic [DEPTH-1:0][WIDTH-1:0] r_taps;

  // Shift one position per clock; loop form also covers DEPTH == 1
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_taps <= '0;
    end else begin
      r_taps[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_taps[i] <= r_taps[i-1];
      end
    end
  end

  assign o_taps = r_taps;

endmodule

// File: rtl/iir_direct_form_i.sv
// M-th order Direct Form I IIR filter, one signed sample per clock.
// y[n] = sat((sum b[k]*x[n-k] + sum a_n[k]*y[n-k]) >>> Q), feedback uses the
// PRECISION-bit saturated state.
// Ports:
//   clk             - clock, rising edge
//   rst             - synchronous active-high reset, clears all history and y
//   x               - signed input sample, accepted every clock
//   packed_a_coeffs - pre-negated feedback coefficients a_n[1..M], a_n[1] in LSBs
//   packed_b_coeffs - feed-forward coefficients b[0..M], b[0] in LSBs
//   y               - registered signed output
module iir_direct_form_i
  import iir_pkg::*;
#(
  parameter int unsigned M            = 2,
  parameter int unsigned INPUT_WIDTH  = 12,
  parameter int unsigned OUTPUT_WIDTH = 16,
  parameter int unsigned PRECISION    = 16,
  parameter int unsigned COEFF_WIDTH  = 16,
  parameter int unsigned Q            = 14
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [INPUT_WIDTH-1:0]     x,
  input  logic [M*COEFF_WIDTH-1:0]          packed_a_coeffs,
  input  logic [(M+1)*COEFF_WIDTH-1:0]      packed_b_coeffs,
  output logic signed [OUTPUT_WIDTH-1:0]    y
);

  localparam int unsigned ACC_W = acc_width(M, INPUT_WIDTH, PRECISION, COEFF_WIDTH);

  logic signed [COEFF_WIDTH-1:0]       w_b [M+1];
  logic signed [COEFF_WIDTH-1:0]       w_a [M];
  logic [M-1:0][INPUT_WIDTH-1:0]       w_x_taps;
  logic [M-1:0][PRECISION-1:0]         w_y_taps;
  logic signed [ACC_W-1:0]             w_acc;
  logic signed [ACC_W-1:0]             w_shifted;
  logic signed [PRECISION-1:0]         w_y_state;
  logic signed [OUTPUT_WIDTH-1:0]      w_y_out;
  logic signed [OUTPUT_WIDTH-1:0]      r_y;

  // Coefficient unpack; w_a[k-1] holds a_n[k]
  always_comb begin : coeff_unpack
    for (int unsigned k = 0; k <= M; k++) begin
      w_b[k] = signed'(packed_b_coeffs[k*COEFF_WIDTH +: COEFF_WIDTH]);
    end
    for (int unsigned k = 0; k < M; k++) begin
      w_a[k] = signed'(packed_a_coeffs[k*COEFF_WIDTH +: COEFF_WIDTH]);
    end
  end

  // Single-cycle multiply-accumulate; feedback must close within one clock
  always_comb begin : mac
    w_acc = ACC_W'(w_b[0]) * ACC_W'(x);
    for (int unsigned k = 1; k <= M; k++) begin
      w_acc = w_acc
            + ACC_W'(w_b[k])   * ACC_W'(signed'(w_x_taps[k-1]))
            + ACC_W'(w_a[k-1]) * ACC_W'(signed'(w_y_taps[k-1]));
    end
  end

  // Floor-rounding scale then clamp to the internal state width
  assign w_shifted = w_acc >>> Q;
  assign w_y_state = PRECISION'(sat(SAT_W'(w_shifted), PRECISION));

  // Map internal state onto the output width
  if (OUTPUT_WIDTH >= PRECISION) begin : g_out_ext
    assign w_y_out = OUTPUT_WIDTH'(w_y_state);
  end else begin : g_out_sat
    assign w_y_out = OUTPUT_WIDTH'(sat(SAT_W'(w_y_state), OUTPUT_WIDTH));
  end

  // Input history x[n-1..n-M]
  iir_delay_line #(
    .WIDTH (INPUT_WIDTH),
    .DEPTH (M)
  ) u_x_line (
    .i_clk  (clk),
    .i_clr  (rst),
    .i_d    (x),
    .o_taps (w_x_taps)
  );

  // Output-state history y_state[n-1..n-M]
  iir_delay_line #(
    .WIDTH (PRECISION),
    .DEPTH (M)
  ) u_y_line (
    .i_clk  (clk),
    .i_clr  (rst),
    .i_d    (w_y_state),
    .o_taps (w_y_taps)
  );

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y <= '0;
    end else begin
      r_y <= w_y_out;
    end
  end

  assign y = r_y;

endmodule

// File: tb/tb_iir_direct_form_i.sv
// Self-checking bench for iir_direct_form_i against a behavioural
// difference-equation model.
module tb_iir_direct_form_i;

  localparam int M  = 2;
  localparam int IW = 12;
  localparam int OW = 16;
  localparam int P  = 16;
  localparam int CW = 16;
  localparam int Q  = 14;

  logic                      clk = 1'b0;
  logic                      rst;
  logic signed [IW-1:0]      x;
  logic [M*CW-1:0]           pa;
  logic [(M+1)*CW-1:0]       pb;
  logic signed [OW-1:0]      y_dut;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: coefficients and sample histories as plain integers
  longint cb [0:M];
  longint ca [1:M];
  longint xh [0:M];
  longint yh [1:M];

  always #5 clk = ~clk;

  iir_direct_form_i #(
    .M            (M),
    .INPUT_WIDTH  (IW),
    .OUTPUT_WIDTH (OW),
    .PRECISION    (P),
    .COEFF_WIDTH  (CW),
    .Q            (Q)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .x               (x),
    .packed_a_coeffs (pa),
    .packed_b_coeffs (pb),
    .y               (y_dut)
  );

  task automatic load_coeffs(input longint b0, input longint b1, input longint b2,
                             input longint a1, input longint a2);
    cb[0] = b0; cb[1] = b1; cb[2] = b2;
    ca[1] = a1; ca[2] = a2;
    pb = {16'(b2), 16'(b1), 16'(b0)};
    pa = {16'(a2), 16'(a1)};
  endtask

  // Reference: y = sat_P(floor((sum b*x + sum a*y) / 2^Q))
  task automatic model_step(input longint xv, input bit r, output longint e);
    longint acc;
    longint hi;
    longint lo;
    if (r) begin
      for (int k = 0; k <= M; k++) xh[k] = 0;
      for (int k = 1; k <= M; k++) yh[k] = 0;
      e = 0;
      return;
    end
    for (int k = M; k >= 1; k--) xh[k] = xh[k-1];
    xh[0] = xv;
    acc = 0;
    for (int k = 0; k <= M; k++) acc += cb[k] * xh[k];
    for (int k = 1; k <= M; k++) acc += ca[k] * yh[k];
    acc = acc >>> Q;
    hi = (longint'(1) <<< (P - 1)) - 1;
    lo = -(longint'(1) <<< (P - 1));
    if (acc > hi) acc = hi;
    else if (acc < lo) acc = lo;
    for (int k = M; k >= 2; k--) yh[k] = yh[k-1];
    yh[1] = acc;
    e = acc;
  endtask

  // Present one sample, clock it, sample y just after the edge
  task automatic cycle(input longint xv, input bit r, output longint e);
    x   = IW'(xv);
    rst = r;
    @(posedge clk);
    #1;
    model_step(xv, r, e);
  endtask

  task automatic test_reset();
    longint e;
    logic signed [OW-1:0] ev;
    load_coeffs(16384, 0, -16384, 0, -8348);
    for (int i = 0; i < 10; i++) begin
      cycle(500, 1'b1, e);
      n_cmp++;
      if (y_dut !== 16'sd0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: y=%0d expected 0", i, y_dut);
      end
    end
    cycle(500, 1'b0, e);
    ev = OW'(e);
    n_cmp++;
    if (y_dut !== 16'sd500) begin
      n_err++;
      $display("FAIL reset_release: y=%0d expected 500", y_dut);
    end
    n_cmp++;
    if (y_dut !== ev) begin
      n_err++;
      $display("FAIL reset_release_model: y=%0d expected %0d", y_dut, ev);
    end
  endtask

  // Impulse of 'amp' after a reset; check model each cycle and listed constants
  task automatic test_impulse(input string name, input longint amp,
                              input int ref_q[$], input int n);
    longint e;
    logic signed [OW-1:0] ev;
    cycle(0, 1'b1, e);
    for (int i = 0; i < n; i++) begin
      cycle((i == 0) ? amp : 0, 1'b0, e);
      ev = OW'(e);
      n_cmp++;
      if (y_dut !== ev) begin
        n_err++;
        $display("FAIL %s_model[%0d]: y=%0d expected %0d", name, i, y_dut, ev);
      end
      if (i < ref_q.size()) begin
        ev = OW'(ref_q[i]);
        n_cmp++;
        if (y_dut !== ev) begin
          n_err++;
          $display("FAIL %s_const[%0d]: y=%0d expected %0d", name, i, y_dut, ev);
        end
      end
    end
  endtask

  task automatic test_passthrough();
    longint e;
    longint xv;
    logic signed [OW-1:0] ev;
    load_coeffs(16384, 0, 0, 0, 0);
    cycle(0, 1'b1, e);
    for (int i = 0; i < 40; i++) begin
      xv = longint'($urandom_range(0, 4095)) - 2048;
      if (i == 0) xv = -2048;
      if (i == 1) xv = 2047;
      cycle(xv, 1'b0, e);
      ev = OW'(xv);
      n_cmp++;
      if (y_dut !== ev) begin
        n_err++;
        $display("FAIL passthrough[%0d]: y=%0d expected %0d", i, y_dut, ev);
      end
      ev = OW'(e);
      n_cmp++;
      if (y_dut !== ev) begin
        n_err++;
        $display("FAIL passthrough_model[%0d]: y=%0d expected %0d", i, y_dut, ev);
      end
    end
  endtask

  task automatic test_saturation();
    longint e;
    logic signed [OW-1:0] ev;
    load_coeffs(32767, 0, 0, 16384, 0);
    cycle(0, 1'b1, e);
    for (int i = 0; i < 30; i++) begin
      cycle(2047, 1'b0, e);
      ev = OW'(e);
      n_cmp++;
      if (y_dut !== ev) begin
        n_err++;
        $display("FAIL saturation_model[%0d]: y=%0d expected %0d", i, y_dut, ev);
      end
      n_cmp++;
      if (y_dut < 0) begin
        n_err++;
        $display("FAIL saturation_wrap[%0d]: y=%0d expected >= 0", i, y_dut);
      end
    end
    n_cmp++;
    if (y_dut !== 16'sd32767) begin
      n_err++;
      $display("FAIL saturation_clamp: y=%0d expected 32767", y_dut);
    end
  endtask

  task automatic test_mid_reset();
    longint e;
    logic signed [OW-1:0] ev;
    logic signed [OW-1:0] rec [10];
    load_coeffs(16384, 0, -16384, 0, -8348);
    cycle(0, 1'b1, e);
    for (int i = 0; i < 10; i++) begin
      cycle((i == 0) ? 1000 : 0, 1'b0, e);
      rec[i] = OW'(e);
      if (i == 4) break;
    end
    cycle(0, 1'b1, e);
    n_cmp++;
    if (y_dut !== 16'sd0) begin
      n_err++;
      $display("FAIL midreset_zero: y=%0d expected 0", y_dut);
    end
    for (int i = 0; i < 10; i++) begin
      cycle((i == 0) ? 1000 : 0, 1'b0, e);
      ev = OW'(e);
      n_cmp++;
      if (y_dut !== ev) begin
        n_err++;
        $display("FAIL midreset_model[%0d]: y=%0d expected %0d", i, y_dut, ev);
      end
      if (i <= 4) begin
        n_cmp++;
        if (y_dut !== rec[i]) begin
          n_err++;
          $display("FAIL midreset_repeat[%0d]: y=%0d expected %0d", i, y_dut, rec[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    longint e;
    longint xv;
    logic signed [OW-1:0] ev;
    bit r;
    for (int i = 0; i < 200; i++) begin
      if (i % 50 == 0) begin
        load_coeffs(longint'($urandom_range(0, 32767)) - 16384,
                    longint'($urandom_range(0, 32767)) - 16384,
                    longint'($urandom_range(0, 32767)) - 16384,
                    longint'($urandom_range(0, 16383)) - 8192,
                    longint'($urandom_range(0, 16383)) - 8192);
      end
      xv = longint'($urandom_range(0, 4095)) - 2048;
      r  = ($urandom_range(0, 39) == 0);
      cycle(xv, r, e);
      ev = OW'(e);
      n_cmp++;
      if (y_dut !== ev) begin
        n_err++;
        $display("FAIL random[%0d]: y=%0d expected %0d", i, y_dut, ev);
      end
    end
  endtask

  initial begin
    int imp_q[$];
    int small_q[$];
    imp_q   = '{1000, 0, -1510, 0, 769, 0, -392};
    small_q = '{1, 0, -2, 0, 1};
    rst = 1'b1;
    x   = '0;
    pa  = '0;
    pb  = '0;
    for (int k = 0; k <= M; k++) xh[k] = 0;
    for (int k = 1; k <= M; k++) yh[k] = 0;
    test_reset();
    test_impulse("impulse", 1000, imp_q, 16);
    test_impulse("small_impulse", 1, small_q, 8);
    test_passthrough();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
